// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the sequential ALU / multiplier: opcodes, FSM states,
// datapath width and multiply iteration count.
package alu_mul_seq_pkg;

    localparam int WIDTH      = 32;
    localparam int MUL_CYCLES = 32;
    localparam int COUNT_W    = $clog2(MUL_CYCLES);

    // ALU opcodes; values are part of the external command encoding.
    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_XOR  = 3'd2,
        ALU_SLT  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_NAND = 3'd5,
        ALU_NOR  = 3'd6,
        ALU_OR   = 3'd7
    } alu_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_mul_seq_alu.sv
// Combinational 32-bit ALU shared by single operations and the multiply loop.
module alu_mul_seq_alu
    import alu_mul_seq_pkg::*;
(
    input  alu_cmd_t          command,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic [WIDTH-1:0]  y
);

    // Opcode decode; SLT is an unsigned compare, zero-extended.
    always_comb begin
        // NOTE: default assigned first so no path leaves y unassigned (no latch).
        y = '0;
        case (command)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_XOR:  y = a ^ b;
            ALU_SLT:  y = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_AND:  y = a & b;
            ALU_NAND: y = ~(a & b);
            ALU_NOR:  y = ~(a | b);
            ALU_OR:   y = a | b;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential ALU front end: one-cycle single operations or a 32-cycle
// shift-and-add multiply, both using the single shared ALU instance.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mul,
    input  logic [2:0]        command,
    input  logic [WIDTH-1:0]  operandA,
    input  logic [WIDTH-1:0]  operandB,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              zero
);

    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(MUL_CYCLES - 1);

    state_t             state, state_next;
    alu_cmd_t           cmd_q;
    logic [WIDTH-1:0]   acc, mcand, mplier;
    logic [COUNT_W-1:0] count;

    alu_cmd_t           alu_cmd;
    logic [WIDTH-1:0]   alu_a, alu_b, alu_y, acc_next;
    logic               accept, last_iter;

    assign accept    = start && (state == ST_IDLE);
    assign last_iter = (count == LAST_COUNT);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    // For single ops the latched operands sit in mcand/mplier; during MUL the
    // ALU adds the shifted multiplicand to the accumulator.
    always_comb begin
        alu_cmd = ALU_ADD;
        alu_a   = mcand;
        alu_b   = mplier;
        if (state == ST_EXEC) begin
            alu_cmd = cmd_q;
        end else if (state == ST_MUL) begin
            alu_a = acc;
            alu_b = mcand;
        end
    end

    assign acc_next = mplier[0] ? alu_y : acc;

    alu_mul_seq_alu u_alu (
        .command (alu_cmd),
        .a       (alu_a),
        .b       (alu_b),
        .y       (alu_y)
    );

    // FSM state register; reset wins over any in-flight operation.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = mul ? ST_MUL : ST_EXEC;
            ST_EXEC: state_next = ST_DONE;
            ST_MUL:  if (last_iter) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand latching, multiply shift registers, and registered result/zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q  <= ALU_ADD;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            result <= '0;
            zero   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_q  <= alu_cmd_t'(command);
                        acc    <= '0;
                        mcand  <= operandA;
                        mplier <= operandB;
                        count  <= '0;
                    end
                end
                ST_EXEC: begin
                    result <= alu_y;
                    zero   <= (alu_y == '0);
                end
                ST_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (last_iter) begin
                        result <= acc_next;
                        zero   <= (acc_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed cases, randomized operations
// and a start-held-high stream compared against a behavioural model.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mul;
    logic [2:0]  command;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    alu_mul_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mul      (mul),
        .command  (command),
        .operandA (operandA),
        .operandB (operandB),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    // Reference behaviour: unsigned product modulo 2^32, or one ALU op.
    function automatic logic [31:0] ref_op(input logic m, input logic [2:0] c,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        if (m) begin
            p = {32'd0, a} * {32'd0, b};
            return p[31:0];
        end
        case (c)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a ^ b;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a & b;
            3'd5: return ~(a & b);
            3'd6: return ~(a | b);
            default: return a | b;
        endcase
    endfunction

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation: accept, wait for done, check latency/busy/result.
    // inject_at > 0 pulses a stray start (A=B=100) that many ticks after accept.
    task automatic run_op(input logic m, input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] b, input int inject_at, input string name);
        logic [31:0] exp_val;
        int n, busy_n, exp_n;
        exp_val  = ref_op(m, c, a, b);
        exp_n    = m ? 33 : 2;
        start    = 1'b1;
        mul      = m;
        command  = c;
        operandA = a;
        operandB = b;
        tick();
        start  = 1'b0;
        n      = 1;
        busy_n = busy ? 1 : 0;
        while (!done && n < 80) begin
            if (n == inject_at) begin
                start = 1'b1; mul = 1'b0; command = 3'd0;
                operandA = 32'd100; operandB = 32'd100;
            end
            tick();
            start = 1'b0;
            n++;
            if (busy) busy_n++;
        end
        checks++;
        if (n !== exp_n) begin
            failures++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, exp_n);
        end
        checks++;
        if (busy_n !== exp_n) begin
            failures++;
            $display("FAIL %s busy_cycles: got %0d, expected %0d", name, busy_n, exp_n);
        end
        checks++;
        if (result !== exp_val) begin
            failures++;
            $display("FAIL %s result: got %h, expected %h", name, result, exp_val);
        end
        checks++;
        if (zero !== (exp_val == 32'd0)) begin
            failures++;
            $display("FAIL %s zero: got %b, expected %b", name, zero, (exp_val == 32'd0));
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL %s after_done busy/done: got %b, expected 00", name, {busy, done});
        end
        checks++;
        if (result !== exp_val) begin
            failures++;
            $display("FAIL %s held_result: got %h, expected %h", name, result, exp_val);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; mul = 1'b1; command = 3'd0;
        operandA = 32'd9; operandB = 32'd9;
        tick();
        tick();
        checks++;
        if ({busy, done, zero} !== 3'b001 || result !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b zero=%b result=%h, expected 0 0 1 0",
                     busy, done, zero, result);
        end
        reset = 1'b0; start = 1'b0;
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release busy/done: got %b, expected 00", {busy, done});
        end
    endtask

    task automatic test_mul_directed();
        run_op(1'b1, 3'd0, 32'd6, 32'd7, 0, "mul_6x7");
        run_op(1'b1, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_ffff");
        run_op(1'b1, 3'd0, 32'h0001_0000, 32'h0001_0000, 0, "mul_overflow_zero");
        run_op(1'b1, 3'd5, 32'd1, 32'd0, 0, "mul_by_zero");
    endtask

    task automatic test_single_ops();
        run_op(1'b0, 3'd1, 32'd5, 32'd7, 0, "sub_5_7");
        run_op(1'b0, 3'd3, 32'd3, 32'd9, 0, "slt_3_9");
        run_op(1'b0, 3'd3, 32'h8000_0000, 32'd1, 0, "slt_unsigned_hi");
        run_op(1'b0, 3'd3, 32'd1, 32'h8000_0000, 0, "slt_unsigned_lo");
        run_op(1'b0, 3'd0, 32'hFFFF_FFFF, 32'd1, 0, "add_wrap");
        for (int c = 0; c < 8; c++) begin
            run_op(1'b0, 3'(c), $urandom, $urandom, 0, $sformatf("op%0d_rand", c));
        end
    endtask

    task automatic test_ignore_start();
        run_op(1'b1, 3'd0, 32'd3, 32'd4, 10, "mul_3x4_stray_start");
    endtask

    task automatic test_reset_mid();
        start = 1'b1; mul = 1'b1; operandA = 32'd5; operandB = 32'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 13; i++) tick();
        reset = 1'b1; start = 1'b1;
        tick();
        checks++;
        if ({busy, done, zero} !== 3'b001 || result !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid state: got busy=%b done=%b zero=%b result=%h, expected 0 0 1 0",
                     busy, done, zero, result);
        end
        reset = 1'b0; start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({busy, done} !== 2'b00) begin
                failures++;
                $display("FAIL reset_mid no_done: got busy/done=%b, expected 00", {busy, done});
            end
        end
        run_op(1'b1, 3'd0, 32'd2, 32'd3, 0, "mul_2x3_after_reset");
    endtask

    task automatic test_random_mul();
        for (int i = 0; i < 6; i++) begin
            run_op(1'b1, 3'($urandom), $urandom, $urandom, 0, "mul_rand");
        end
        run_op(1'b1, 3'd0, $urandom, 32'd1, 0, "mul_by_one");
    endtask

    // start held high with fresh random inputs every cycle; the model accepts
    // only when idle and tracks remaining cycles until done.
    task automatic test_back_to_back();
        int left = 0;
        int dones = 0, exp_dones = 0;
        logic exp_done;
        logic [31:0] exp_val = '0;
        for (int i = 0; i < 160; i++) begin
            start    = 1'b1;
            mul      = ($urandom_range(0, 3) == 0);
            command  = 3'($urandom);
            operandA = $urandom;
            operandB = (i % 2) ? 32'($urandom_range(0, 50)) : $urandom;
            if (left == 0) begin
                exp_val  = ref_op(mul, command, operandA, operandB);
                left     = (mul ? 32 : 1) + 1;
                exp_done = 1'b0;
            end else begin
                left--;
                exp_done = (left == 1);
            end
            tick();
            if (exp_done) exp_dones++;
            if (done) dones++;
            checks++;
            if (done !== exp_done) begin
                failures++;
                $display("FAIL b2b done@%0d: got %b, expected %b", i, done, exp_done);
            end
            if (exp_done) begin
                checks++;
                if (result !== exp_val) begin
                    failures++;
                    $display("FAIL b2b result@%0d: got %h, expected %h", i, result, exp_val);
                end
            end
        end
        start = 1'b0;
        for (int i = 0; i < 40 && busy; i++) tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b drain: busy still %b after bound", busy);
        end
        checks++;
        if (dones !== exp_dones) begin
            failures++;
            $display("FAIL b2b done_count: got %0d, expected %0d", dones, exp_dones);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mul = 1'b0; command = 3'd0;
        operandA = '0; operandB = '0;
        test_reset();
        test_mul_directed();
        test_single_ops();
        test_ignore_start();
        test_reset_mid();
        test_random_mul();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
